rx_fifo_circ: RTL and testbench
===============================

// Module: rx_fifo_circ
// PURPOSE
//   Parametrised circular receive FIFO between the UART receiver and the interface
//   logic. Successor to the one-word RX holding buffer: 2**NB_ADDR entries, full,
//   almost-full and occupancy outputs, and a sticky overflow flag.
//   First-word-fall-through: the oldest word is presented on data_out while empty=0.
// PARAMETERS
//   NB_DATA    8    data word width, bits
//   NB_ADDR    4    address width; DEPTH = 2**NB_ADDR entries (16 by default)
//   AFULL_LVL  12   almost_full asserts when count >= AFULL_LVL (legal range 1..DEPTH)
// PORTS
//   clk          in   1          system clock; all logic on posedge
//   reset        in   1          synchronous, active-high reset
//   wr           in   1          write strobe from UART RX, 1-cycle pulse per word
//   data_in      in   NB_DATA    word written when wr=1
//   rd           in   1          pop strobe from interface; consumes data_out
//   data_out     out  NB_DATA    oldest stored word (FWFT); valid only while empty=0
//   empty        out  1          no words stored
//   full         out  1          DEPTH words stored
//   almost_full  out  1          count >= AFULL_LVL
//   count        out  NB_ADDR+1  words stored, 0..DEPTH
//   overflow     out  1          sticky: a write was dropped because FIFO was full
//   clr_ovf      in   1          clears overflow on the next edge
// BEHAVIOUR
//   - Storage: DEPTH x NB_DATA array, not reset. wr_ptr/rd_ptr NB_ADDR bits, wrap
//     DEPTH-1 -> 0 naturally. count register NB_ADDR+1 bits.
//   - Reset (reset=1 at posedge): wr_ptr=0, rd_ptr=0, count=0, overflow=0. Outputs after
//     reset: empty=1, full=0, almost_full=0, count=0, overflow=0; data_out don't-care.
//     Reset overrides every other input, including mid-burst wr/rd; contents discarded.
//   - Flags are decoded from registered count: empty=(count==0), full=(count==DEPTH),
//     almost_full=(count>=AFULL_LVL). No combinational path from wr/rd to any flag.
//   - data_out = mem[rd_ptr] (combinational read of registered state).
//   - Write accepted = wr & (~full | rd_acc). Accepted: mem[wr_ptr]<=data_in, wr_ptr+1.
//   - Read accepted  rd_acc = rd & ~empty. Accepted: rd_ptr+1. rd while empty ignored,
//     no state change, no error flag.
//   - count next: +1 on write-only, -1 on read-only, unchanged on both or neither.
//   - Latency: word written at edge N is on data_out with empty=0 after edge N
//     (i.e. usable in cycle N+1) when the FIFO was empty; 1 cycle wr-to-visible.
//   - Simultaneous wr & rd:
//       empty: write accepted, read ignored -> count 1.
//       full : both accepted, count stays DEPTH, overflow NOT set, oldest word replaced
//              in order (new word enters at wr_ptr==rd_ptr slot after pop).
//       other: both accepted, count unchanged.
//   - Overflow: wr & full & ~rd -> data_in dropped, no pointer/count change,
//     overflow<=1. Stays 1 until clr_ovf=1 or reset. Same-cycle drop and clr_ovf:
//     set wins (overflow=1).
//   - No state machine beyond pointers/count; behaviour fully defined by the rules above.
// TESTING
//   1 reset, then wr data_in=8'hA5 one cycle -> next cycle empty=0, count=1,
//     data_out=8'hA5; rd one cycle -> empty=1, count=0.
//   2 write 16 words 8'h00..8'h0F -> almost_full=1 once count=12, full=1 at 16;
//     read 16 -> data_out sequence 00..0F in order, empty=1 at end.
//   3 wraparound: write 10, read 10, write 16 (8'h20..8'h2F), read 16 -> order
//     8'h20..8'h2F intact across pointer wrap; count never exceeds 16.
//   4 full, wr=1 data_in=8'hFF, rd=0 -> overflow=1, count=16, 8'hFF never read out;
//     clr_ovf pulse -> overflow=0; drop+clr_ovf same cycle -> overflow=1.
//   5 full, wr&rd same cycle with 8'h77 -> count=16, overflow=0, 8'h77 read out last;
//     empty, wr&rd same cycle with 8'h55 -> count=1, data_out=8'h55.
//   6 8 words stored, overflow=1, assert reset mid wr/rd burst -> next cycle
//     empty=1, count=0, full=0, almost_full=0, overflow=0; rd while empty -> no change.

Source files
------------

// File: rtl/rx_fifo_circ.sv
// Circular first-word-fall-through receive FIFO between the UART receiver and the interface logic.
// It provides flags decoded from the registered count and a sticky overflow flag for dropped writes.
module rx_fifo_circ #(
  parameter int unsigned NB_DATA   = 8,
  parameter int unsigned NB_ADDR   = 4,
  parameter int unsigned AFULL_LVL = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [NB_DATA-1:0] data_in,
  input  logic               rd,
  output logic [NB_DATA-1:0] data_out,
  output logic               empty,
  output logic               full,
  output logic               almost_full,
  output logic [NB_ADDR:0]   count,
  output logic               overflow,
  input  logic               clr_ovf
);

  localparam int unsigned       DEPTH     = 1 << NB_ADDR;
  localparam logic [NB_ADDR:0] DEPTH_CNT = {1'b1, {NB_ADDR{1'b0}}};
  localparam logic [NB_ADDR:0] AFULL_CNT = (NB_ADDR+1)'(AFULL_LVL);

  logic [NB_DATA-1:0] mem [DEPTH];
  logic [NB_ADDR-1:0] wr_ptr;
  logic [NB_ADDR-1:0] rd_ptr;
  logic               rd_acc;
  logic               wr_acc;
  logic               drop;

  assign empty       = (count == '0);
  assign full        = (count == DEPTH_CNT);
  assign almost_full = (count >= AFULL_CNT);
  assign data_out    = mem[rd_ptr];

  // When the FIFO is full, a simultaneous pop frees the slot that the incoming word takes.
  assign rd_acc = rd & ~empty;
  assign wr_acc = wr & (~full | rd_acc);
  assign drop   = wr & full & ~rd;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + NB_ADDR'(1);
      if (rd_acc) rd_ptr <= rd_ptr + NB_ADDR'(1);
      if (wr_acc && !rd_acc)      count <= count + (NB_ADDR+1)'(1);
      else if (rd_acc && !wr_acc) count <= count - (NB_ADDR+1)'(1);
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_fifo_circ.sv
// Directed self-checking bench for rx_fifo_circ with default parameters (16 entries, almost_full at 12).
module tb_rx_fifo_circ;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr;
  logic [7:0] data_in;
  logic       rd;
  logic [7:0] data_out;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [4:0] count;
  logic       overflow;
  logic       clr_ovf;

  int checks   = 0;
  int failures = 0;

  rx_fifo_circ #(.NB_DATA(8), .NB_ADDR(4), .AFULL_LVL(12)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr),
    .data_in     (data_in),
    .rd          (rd),
    .data_out    (data_out),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .clr_ovf     (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                     input logic c, input logic rs = 1'b0);
    wr = w; data_in = d; rd = r; clr_ovf = c; reset = rs;
    @(posedge clk);
    #1;
    wr = 1'b0; data_in = 8'h00; rd = 1'b0; clr_ovf = 1'b0; reset = 1'b0;
  endtask

  initial begin
    wr = 1'b0; data_in = 8'h00; rd = 1'b0; clr_ovf = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    cyc(0, 8'h00, 0, 0, 1'b1);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);

    // 1: single word latency
    cyc(1, 8'hA5, 0, 0);
    chk("t1_empty", empty, 0);
    chk("t1_count", count, 1);
    chk("t1_data", data_out, 8'hA5);
    cyc(0, 8'h00, 1, 0);
    chk("t1_empty_after_rd", empty, 1);
    chk("t1_count_after_rd", count, 0);

    // 2: fill to 16, flags at thresholds, drain in order
    for (int i = 0; i < 16; i++) begin
      cyc(1, 8'(i), 0, 0);
      chk("t2_count", count, i + 1);
      chk("t2_afull", almost_full, (i + 1 >= 12) ? 1 : 0);
      chk("t2_full", full, (i == 15) ? 1 : 0);
    end
    for (int i = 0; i < 16; i++) begin
      chk("t2_data", data_out, i);
      cyc(0, 8'h00, 1, 0);
    end
    chk("t2_empty_end", empty, 1);
    chk("t2_count_end", count, 0);

    // 3: pointer wrap
    for (int i = 0; i < 10; i++) cyc(1, 8'(8'h10 + i), 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("t3_pre_data", data_out, 8'h10 + i);
      cyc(0, 8'h00, 1, 0);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1, 8'(8'h20 + i), 0, 0);
      chk("t3_count", count, i + 1);
    end
    chk("t3_full", full, 1);
    for (int i = 0; i < 16; i++) begin
      chk("t3_data", data_out, 8'h20 + i);
      cyc(0, 8'h00, 1, 0);
    end
    chk("t3_empty_end", empty, 1);

    // 4: overflow drop, clear, drop and clear in the same cycle
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h30 + i), 0, 0);
    cyc(1, 8'hFF, 0, 0);
    chk("t4_ovf_set", overflow, 1);
    chk("t4_count", count, 16);
    cyc(0, 8'h00, 0, 1);
    chk("t4_ovf_clr", overflow, 0);
    cyc(1, 8'hFF, 0, 1);
    chk("t4_ovf_set_wins", overflow, 1);
    chk("t4_count2", count, 16);
    for (int i = 0; i < 16; i++) begin
      chk("t4_data", data_out, 8'h30 + i);
      cyc(0, 8'h00, 1, 0);
    end
    chk("t4_empty_end", empty, 1);
    chk("t4_ovf_sticky", overflow, 1);
    cyc(0, 8'h00, 0, 1);
    chk("t4_ovf_clr2", overflow, 0);

    // 5: simultaneous wr and rd while full, then while empty
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h40 + i), 0, 0);
    cyc(1, 8'h77, 1, 0);
    chk("t5_full_count", count, 16);
    chk("t5_full_ovf", overflow, 0);
    chk("t5_full_flag", full, 1);
    for (int i = 1; i < 16; i++) begin
      chk("t5_data", data_out, 8'h40 + i);
      cyc(0, 8'h00, 1, 0);
    end
    chk("t5_last", data_out, 8'h77);
    cyc(0, 8'h00, 1, 0);
    chk("t5_empty", empty, 1);
    cyc(1, 8'h55, 1, 0);
    chk("t5_empty_count", count, 1);
    chk("t5_empty_data", data_out, 8'h55);
    chk("t5_empty_flag", empty, 0);
    cyc(0, 8'h00, 1, 0);
    chk("t5_drained", count, 0);

    // 6: reset in the middle of a wr/rd burst
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h60 + i), 0, 0);
    cyc(1, 8'hFF, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 0);
    chk("t6_pre_count", count, 8);
    chk("t6_pre_ovf", overflow, 1);
    chk("t6_pre_afull", almost_full, 0);
    chk("t6_pre_data", data_out, 8'h68);
    cyc(1, 8'h99, 1, 0);
    chk("t6_burst_count", count, 8);
    cyc(1, 8'h9A, 1, 0, 1'b1);
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_full", full, 0);
    chk("t6_rst_afull", almost_full, 0);
    chk("t6_rst_ovf", overflow, 0);
    cyc(0, 8'h00, 1, 0);
    chk("t6_rd_empty", empty, 1);
    chk("t6_rd_count", count, 0);
    chk("t6_rd_ovf", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
